dmem_lane_arbiter: RTL
======================

// Module: dmem_lane_arbiter
// PURPOSE
//  Shares the single-port data memory between the two issue lanes of the superscalar core.
//  Each lane presents a load/store request with a valid/ready handshake.
//  The arbiter grants one request at a time, round-robin, and sequences the memory access over MEM_LAT cycles.
//  It returns a one-cycle response (read data) to the owning lane.
//  Sits between the two lane datapaths and Data_Memory (mem_we -> WE, mem_addr -> A, mem_wdata -> WD, RD -> mem_rdata).
// PARAMETERS
//  AW       32  address width (byte address, passed through unmodified)
//  DW       32  data width
//  MEM_LAT  1   memory cycles from address presentation to rdata sampled; legal range 1..15
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset (0 = reset asserted)
//  req0_valid   in   1   lane0 request pending; held with stable fields until req0_ready
//  req0_we      in   1   lane0 store (1) / load (0)
//  req0_addr    in   AW  lane0 address
//  req0_wdata   in   DW  lane0 store data
//  req0_ready   out  1   lane0 request accepted this cycle (combinational, IDLE only)
//  rsp0_valid   out  1   lane0 response, one-cycle pulse
//  rsp0_rdata   out  DW  lane0 load data (0 for stores)
//  req1_*/rsp1_*        identical set for lane1
//  mem_we       out  1   memory write strobe
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data (combinational from mem_addr)
//  busy         out  1   access in flight (state == ACCESS)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, last_grant=1 (lane0 wins first), cnt=0.
//    All outputs 0: readies, rsp*_valid, rsp*_rdata, mem_we, mem_addr, mem_wdata, busy.
//  - Reset mid-access aborts the access: no response is issued, and mem_we drops immediately.
//  - FSM IDLE:
//    * Select a lane if any reqN_valid=1; with both valid, grant the lane != last_grant.
//    * Assert that lane's reqN_ready in the same cycle. Never both readies in one cycle.
//    * Register we/addr/wdata/owner; last_grant<=owner; cnt<=MEM_LAT-1; go to ACCESS.
//  - FSM ACCESS:
//    * mem_addr/mem_wdata are driven from the registered request.
//    * mem_we=registered we in the first ACCESS cycle only; the write strobe is exactly one cycle.
//    * reqN_ready=0 throughout ACCESS.
//    * cnt decrements each cycle. At cnt==0: rsp_rdata<=(we ? 0 : mem_rdata), rsp_valid for owner <= 1, go to IDLE.
//  - Timing, accept at cycle T:
//    * Address on the memory port during T+1..T+MEM_LAT.
//    * rdata sampled at the end of T+MEM_LAT.
//    * rspN_valid=1 in T+MEM_LAT+1 only.
//    * The IDLE cycle T+MEM_LAT+1 may accept the next request (response and accept coincide).
//    * Peak throughput: one access per MEM_LAT+1 cycles.
//  - rspN_rdata holds its value until the next response to that lane. The other lane's rsp_valid stays 0.
//  - mem_addr/mem_wdata hold their last value in IDLE; mem_we=0 in IDLE.
//  - A lane dropping valid before ready is a protocol violation. The arbiter re-evaluates every IDLE cycle and stores nothing.
//  - Ordering between lanes is the issue logic's responsibility. The arbiter guarantees only no starvation: max wait is one foreign access.
// TESTING
//  1. Assert reset=0 during ACCESS of a lane1 store -> all outputs 0 at once, no rsp1. After release, simultaneous req0/req1 -> lane0 granted.
//  2. MEM_LAT=1, lane0 load addr 0x10, memory returns 0xDEADBEEF -> req0_ready at T, mem_addr=0x10 at T+1, rsp0_valid=1 with 0xDEADBEEF at T+2 only, rsp1_valid=0.
//  3. lane1 store addr 0x20 wdata 0x1234 -> mem_we=1 only at T+1 with mem_addr=0x20, mem_wdata=0x1234; rsp1_valid at T+2, rsp1_rdata=0.
//  4. Both lanes valid continuously, 4 requests each, MEM_LAT=1 -> grants 0,1,0,1,...; accepts every 2 cycles; each response goes to the correct lane with the correct data.
//  5. MEM_LAT=3, lane0 load accepted at T, req1 raised at T+1 -> req1_ready stays 0 until T+4; rsp0_valid at T+4, same cycle as req1_ready; rsp1 at T+8.
//  6. Single lane0 streaming loads (0x0,0x4,0x8) with lane1 idle -> back-to-back grants to lane0 every MEM_LAT+1 cycles, no bubbles beyond that.

Source files
------------

// File: rtl/dmem_lane_arbiter.sv
// dmem_lane_arbiter: round-robin sharing of the single-port data memory between two issue lanes,
// one access in flight at a time, MEM_LAT cycles per access, one-cycle response pulse to the owner.
module dmem_lane_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nx;
    logic       last_grant, owner, we_r, pick, take;
    logic [3:0] cnt;

    // readies are gated by reset so they read 0 while reset is held
    always_comb begin
        pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        take       = reset && state == IDLE && (req0_valid || req1_valid);
        req0_ready = take && !pick;
        req1_ready = take && pick;
        state_nx   = take ? ACCESS : (state == ACCESS && cnt == 4'd0) ? IDLE : state;
    end

    assign busy   = state == ACCESS;
    assign mem_we = busy && we_r && cnt == 4'(MEM_LAT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_r       <= 1'b0;
            cnt        <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= state_nx;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (take) begin
                owner      <= pick;
                last_grant <= pick;
                we_r       <= pick ? req1_we : req0_we;
                mem_addr   <= pick ? req1_addr : req0_addr;
                mem_wdata  <= pick ? req1_wdata : req0_wdata;
                cnt        <= 4'(MEM_LAT - 1);
            end else if (busy) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd0) begin
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    if (owner) rsp1_rdata <= we_r ? '0 : mem_rdata;
                    else       rsp0_rdata <= we_r ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule
